// File: rtl/codec_map_dec_output_buffer_pkg.sv
// codec_map_dec_output_buffer_pkg: read FSM states, skid FIFO depth and bank addressing for the MAP decoder output buffer
package codec_map_dec_output_buffer_pkg;

    typedef enum logic {IDLE, READ} rd_state_t;

    localparam int cFIFO_DEPTH = 2;

    // Row inside a bank: frame buffer select on top, frame address without its bank bit below
    function automatic int unsigned bank_idx(input logic bsel, input int unsigned addr, input int unsigned addr_w);
        return ({31'd0, bsel} << (addr_w - 1)) | (addr >> 1);
    endfunction

endpackage

// File: rtl/codec_map_dec_output_ram.sv
// codec_map_dec_output_ram: odd/even banked frame RAM, two switched write ports, one read port with 1-tick latency
//   iclk, iclkena      : clock and clock enable
//   iwrite, iwbuf      : write strobe and frame buffer being written
//   iwaddr0/1, iwdata0/1 : write ports; the odd address goes to bank0, the even one to bank1
//   irbuf, iraddr      : frame buffer and address being read
//   ordata             : read data, valid the tick after the read
module codec_map_dec_output_ram
    import codec_map_dec_output_buffer_pkg::*;
#(
    parameter int pDATA_W = 8,
    parameter int pADDR_W = 8
) (
    input  logic               iclk,
    input  logic               iclkena,
    input  logic               iwrite,
    input  logic               iwbuf,
    input  logic [pADDR_W-1:0] iwaddr0,
    input  logic [pDATA_W-1:0] iwdata0,
    input  logic [pADDR_W-1:0] iwaddr1,
    input  logic [pDATA_W-1:0] iwdata1,
    input  logic               irbuf,
    input  logic [pADDR_W-1:0] iraddr,
    output logic [pDATA_W-1:0] ordata
);

    localparam int cDEPTH = 2 ** pADDR_W;

    logic [pDATA_W-1:0] bank0 [cDEPTH];
    logic [pDATA_W-1:0] bank1 [cDEPTH];
    logic [pDATA_W-1:0] rd0, rd1, d0, d1;
    logic [pADDR_W-1:0] a0, a1, ri;
    logic               rsel;

    always_comb begin
        a0 = pADDR_W'(bank_idx(iwbuf, 32'(iwaddr0[0] ? iwaddr0 : iwaddr1), pADDR_W));
        a1 = pADDR_W'(bank_idx(iwbuf, 32'(iwaddr0[0] ? iwaddr1 : iwaddr0), pADDR_W));
        d0 = iwaddr0[0] ? iwdata0 : iwdata1;
        d1 = iwaddr0[0] ? iwdata1 : iwdata0;
        ri = pADDR_W'(bank_idx(irbuf, 32'(iraddr), pADDR_W));
    end

    // Reads sample the old contents, so a buffer released at its last read can be rewritten the next tick
    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (iwrite) begin
                bank0[a0] <= d0;
                bank1[a1] <= d1;
            end
            rd0  <= bank0[ri];
            rd1  <= bank1[ri];
            rsel <= iraddr[0];
        end
    end

    assign ordata = rsel ? rd0 : rd1;

endmodule

// File: rtl/codec_map_dec_output_buffer.sv
// codec_map_dec_output_buffer: ping-pong frame buffer filled by the MAP decoder two words per tick, streamed out one word per tick
//   iclk, ireset, iclkena : clock, synchronous active-high reset, clock enable
//   iwrite, iwaddr0/1, iwdata0/1 : paired write from the decoder (one odd, one even address)
//   iwfull, ilast, owfull : frame handoff with its last address; owfull = no free buffer
//   iready, oval, odat, osop, oeop : output stream with valid/ready handshake and frame marks
module codec_map_dec_output_buffer
    import codec_map_dec_output_buffer_pkg::*;
#(
    parameter int pDATA_W = 8,
    parameter int pADDR_W = 8
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               iwrite,
    input  logic [pADDR_W-1:0] iwaddr0,
    input  logic [pDATA_W-1:0] iwdata0,
    input  logic [pADDR_W-1:0] iwaddr1,
    input  logic [pDATA_W-1:0] iwdata1,
    input  logic               iwfull,
    input  logic [pADDR_W-1:0] ilast,
    output logic               owfull,
    input  logic               iready,
    output logic               oval,
    output logic [pDATA_W-1:0] odat,
    output logic               osop,
    output logic               oeop
);

    rd_state_t                   state, state_n;
    logic [1:0]                  full, full_n;
    logic [1:0][pADDR_W-1:0]     last;
    logic                        wbuf, rbuf, wfull_ok, rel, issue, pop;
    logic                        infl, infl_sop, infl_eop, wp, rp;
    logic [pADDR_W-1:0]          raddr, cur_addr;
    logic [pDATA_W-1:0]          rdata;
    logic [1:0]                  cnt, occ;
    logic [pDATA_W+1:0]          fifo [cFIFO_DEPTH];
    logic [pDATA_W+1:0]          head;

    codec_map_dec_output_ram #(.pDATA_W(pDATA_W), .pADDR_W(pADDR_W)) u_ram (
        .iclk    (iclk),
        .iclkena (iclkena),
        .iwrite  (iwrite & ~owfull),
        .iwbuf   (wbuf),
        .iwaddr0 (iwaddr0),
        .iwdata0 (iwdata0),
        .iwaddr1 (iwaddr1),
        .iwdata1 (iwdata1),
        .irbuf   (rbuf),
        .iraddr  (cur_addr),
        .ordata  (rdata)
    );

    assign head = fifo[rp];
    assign oval = cnt != 2'd0;
    assign odat = head[pDATA_W+1:2];
    assign osop = oval & head[1];
    assign oeop = oval & head[0];
    assign pop  = oval & iready;

    // Address 0 is issued straight from IDLE so the first word appears two ticks after handoff;
    // credit counts the FIFO after this tick's pop so a steady stream runs at one word per tick
    always_comb begin
        wfull_ok = iwfull & ~owfull;
        cur_addr = (state == READ) ? raddr : '0;
        occ      = cnt - {1'b0, pop} + {1'b0, infl};
        issue    = ((state == READ) | full[rbuf]) & (occ < 2'(cFIFO_DEPTH));
        rel      = issue & (cur_addr == last[rbuf]);
        state_n  = rel ? IDLE : issue ? READ : state;
        full_n   = full;
        if (rel)
            full_n[rbuf] = 1'b0;
        if (wfull_ok)
            full_n[wbuf] = 1'b1;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state    <= IDLE;
            full     <= '0;
            last     <= '0;
            wbuf     <= 1'b0;
            rbuf     <= 1'b0;
            owfull   <= 1'b0;
            raddr    <= '0;
            infl     <= 1'b0;
            infl_sop <= 1'b0;
            infl_eop <= 1'b0;
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= '0;
            fifo     <= '{default: '0};
        end else if (iclkena) begin
            state    <= state_n;
            full     <= full_n;
            if (wfull_ok)
                last[wbuf] <= ilast;
            wbuf     <= wbuf ^ wfull_ok;
            rbuf     <= rbuf ^ rel;
            owfull   <= full_n[wbuf ^ wfull_ok];
            raddr    <= issue ? cur_addr + 1'b1 : raddr;
            infl     <= issue;
            infl_sop <= cur_addr == '0;
            infl_eop <= rel;
            if (infl)
                fifo[wp] <= {rdata, infl_sop, infl_eop};
            wp       <= wp ^ infl;
            rp       <= rp ^ pop;
            cnt      <= cnt + {1'b0, infl} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_codec_map_dec_output_buffer.sv
// tb_codec_map_dec_output_buffer: scoreboard bench, frames written by the bench are expected verbatim on the output stream
module tb_codec_map_dec_output_buffer;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          iclk = 0, ireset = 1, iclkena = 1, iwrite = 0, iwfull = 0, iready = 0;
    logic [AW-1:0] iwaddr0 = 0, iwaddr1 = 0, ilast = 0;
    logic [DW-1:0] iwdata0 = 0, iwdata1 = 0;
    logic          owfull, oval, osop, oeop;
    logic [DW-1:0] odat;

    int checks = 0, errors = 0, n_xfer = 0, pend = 0, mode = 0, pat_i = 0;
    logic [9:0]    expq [$];
    logic          hold_v = 0;
    logic [DW-1:0] hold_d = 0;

    codec_map_dec_output_buffer #(.pDATA_W(DW), .pADDR_W(AW)) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .iwrite  (iwrite),
        .iwaddr0 (iwaddr0),
        .iwdata0 (iwdata0),
        .iwaddr1 (iwaddr1),
        .iwdata1 (iwdata1),
        .iwfull  (iwfull),
        .ilast   (ilast),
        .owfull  (owfull),
        .iready  (iready),
        .oval    (oval),
        .odat    (odat),
        .osop    (osop),
        .oeop    (oeop)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // mode 1: random iready, mode 2: fixed 1,0,0,1,0,1 pattern
    task automatic tick;
        @(posedge iclk);
        #1;
        if (mode == 1)
            iready = 1'($urandom_range(0, 1));
        else if (mode == 2) begin
            iready = (pat_i % 6 == 0) || (pat_i % 6 == 3) || (pat_i % 6 == 5);
            pat_i++;
        end
    endtask

    // Writes addresses 0..last in pairs, then hands the frame over; accepted frames become expected output
    task automatic send_frame(input int last, input bit swap, input bit accept, input bit fixed, input bit comb);
        logic [DW-1:0] d [64];
        int npairs;
        for (int a = 0; a < 64; a++)
            d[a] = fixed ? DW'(8'h10 + a) : DW'($urandom);
        npairs = last / 2 + 1;
        for (int k = 0; k < npairs; k++) begin
            iwrite  = 1;
            iwaddr0 = AW'(swap ? 2 * k + 1 : 2 * k);
            iwaddr1 = AW'(swap ? 2 * k : 2 * k + 1);
            iwdata0 = d[iwaddr0];
            iwdata1 = d[iwaddr1];
            if (comb && k == npairs - 1) begin
                iwfull = 1;
                ilast  = AW'(last);
            end
            tick();
        end
        iwrite = 0;
        if (!comb) begin
            iwfull = 1;
            ilast  = AW'(last);
            tick();
        end
        iwfull = 0;
        if (accept) begin
            for (int a = 0; a <= last; a++)
                expq.push_back({d[a], a == 0, a == last});
            pend++;
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && expq.size() != 0; i++)
            tick();
        chk("drain_left", expq.size(), 0);
        repeat (3) tick();
        chk("idle_oval", oval, 0);
    endtask

    task automatic wait_pend;
        for (int i = 0; i < 3000 && pend > 1; i++)
            tick();
        chk("pend_wait", pend > 1, 0);
    endtask

    always @(negedge iclk) begin
        if (ireset)
            hold_v = 0;
        else if (iclkena) begin
            if (hold_v) begin
                chk("hold_oval", oval, 1);
                chk("hold_odat", odat, hold_d);
            end
            hold_v = oval && !iready;
            hold_d = odat;
            if (oval && iready) begin
                n_xfer++;
                if (expq.size() == 0)
                    chk("unexpected_word", {odat, osop, oeop}, 32'hFFFF_FFFF);
                else begin
                    logic [9:0] e;
                    e = expq.pop_front();
                    chk("word", {odat, osop, oeop}, e);
                    if (e[0])
                        pend--;
                end
            end
        end
    end

    initial begin
        int base;
        logic [DW-1:0] fd;
        logic fv;
        repeat (3) tick();
        chk("rst_oval", oval, 0);
        chk("rst_osop", osop, 0);
        chk("rst_oeop", oeop, 0);
        chk("rst_owfull", owfull, 0);
        chk("rst_odat", odat, 0);
        ireset = 0;
        tick();

        iready = 1;
        send_frame(7, 0, 1, 1, 0);
        chk("lat0", oval, 0);
        tick();
        chk("lat1", oval, 0);
        tick();
        chk("lat2", oval, 1);
        drain(100);

        send_frame(7, 1, 1, 1, 0);
        drain(100);

        base = n_xfer;
        mode = 2;
        pat_i = 0;
        send_frame(7, 0, 1, 1, 0);
        drain(200);
        mode = 0;
        chk("bp_count", n_xfer - base, 8);

        iready = 1;
        send_frame(0, 0, 1, 0, 0);
        drain(100);

        iready = 0;
        send_frame(3, 0, 1, 0, 0);
        chk("pp_owfull_a", owfull, 0);
        send_frame(5, 1, 1, 0, 0);
        chk("pp_owfull_b", owfull, 1);
        send_frame(7, 0, 0, 0, 0);
        chk("pp_owfull_c", owfull, 1);
        repeat (3) tick();
        base = n_xfer;
        iready = 1;
        tick();
        chk("pp_owfull_s1", owfull, 1);
        tick();
        chk("pp_owfull_s2", owfull, 0);
        repeat (8) tick();
        chk("pp_nobubble", n_xfer - base, 10);
        drain(100);

        send_frame(7, 0, 1, 0, 0);
        repeat (4) tick();
        ireset = 1;
        expq.delete();
        pend = 0;
        tick();
        ireset = 0;
        chk("mid_rst_oval", oval, 0);
        chk("mid_rst_owfull", owfull, 0);
        send_frame(9, 1, 1, 0, 1);
        drain(100);

        send_frame(7, 0, 1, 0, 0);
        repeat (3) tick();
        fd = odat;
        fv = oval;
        iclkena = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_oval", oval, fv);
            chk("frz_odat", odat, fd);
        end
        iclkena = 1;
        drain(100);

        mode = 1;
        for (int f = 0; f < 10; f++) begin
            wait_pend();
            send_frame($urandom_range(0, 20), 1'($urandom_range(0, 1)), 1, 0, 1'($urandom_range(0, 1)));
        end
        drain(4000);
        mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
